// File: rtl/reverse_arbiter.sv
// Two-requester round-robin arbiter with a one-entry output slot.
// The granted request vector is bit-reversed into the slot.
// A running count of drained results is kept in done_count.
module reverse_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_next;
    logic             last_grant;
    logic             grant;
    logic             grant_valid;
    logic             load_en;
    logic             req_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] rev_data;

    assign out_valid = (state == FULL);

    // The slot can take a new vector when it is empty or draining this cycle.
    assign load_en  = !out_valid || out_ready;
    assign out_xfer = out_valid && out_ready;

    // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        grant_valid = req0_valid || req1_valid;
        grant       = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    // Readys are held low during reset so nothing is accepted while rst_n=0.
    assign req0_ready = rst_n && load_en && grant_valid && !grant;
    assign req1_ready = rst_n && load_en && grant_valid &&  grant;
    assign req_xfer   = req0_ready || req1_ready;

    assign sel_data = grant ? req1_data : req0_data;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_rev
            assign rev_data[i] = sel_data[WIDTH-1-i];
        end
    endgenerate

    // Slot occupancy state register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_next;
    end

    // Fill on accept; empty only when drained with no refill in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (req_xfer)              state_next = FULL;
            FULL:  if (out_xfer && !req_xfer) state_next = EMPTY;
            default:                          state_next = EMPTY;
        endcase
    end

    // Result slot and arbitration history; last_grant=1 lets requester 0 win first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (req_xfer) begin
            out_data   <= rev_data;
            out_id     <= grant;
            last_grant <= grant;
        end
    end

    // Completed output transfers, wrapping naturally at the counter width.
    always_ff @(posedge clk) begin
        if (!rst_n)
            done_count <= '0;
        else if (out_xfer)
            done_count <= done_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_reverse_arbiter.sv
// Self-checking bench for reverse_arbiter: directed scenarios plus a
// scoreboard/reference monitor that checks every accepted vector and ready.
module tb_reverse_arbiter;

    localparam int W = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, out_ready;
    logic [W-1:0]  req0_data, req1_data;
    logic          req0_ready, req1_ready, out_valid, out_id;
    logic [W-1:0]  out_data;
    logic [CW-1:0] done_count;

    int n_cmp = 0;
    int n_err = 0;

    // reference state for the monitor
    logic          m_full, m_last;
    logic [CW-1:0] m_cnt;
    int            st0, st1;
    logic [W:0]    sb[$];

    reverse_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .done_count(done_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rev(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = d[W-1-k];
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference model + scoreboard, evaluated mid-cycle ahead of the next edge.
    always @(negedge clk) begin
        logic ld, gv, g, e0, e1, rx, ox;
        logic [W:0] exp_v;
        if (!rst_n) begin
            n_cmp++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL rst_ready: got %b%b required 00", req0_ready, req1_ready);
            end
            m_full = 1'b0; m_last = 1'b1; m_cnt = '0;
            sb.delete(); st0 = 0; st1 = 0;
        end else begin
            ld = !m_full || out_ready;
            gv = req0_valid || req1_valid;
            g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            e0 = ld && gv && !g;
            e1 = ld && gv && g;
            n_cmp++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                n_err++;
                $display("FAIL mon_ready: got %b%b required %b%b", req0_ready, req1_ready, e0, e1);
            end
            n_cmp++;
            if (out_valid !== m_full) begin
                n_err++;
                $display("FAIL mon_out_valid: got %b required %b", out_valid, m_full);
            end
            n_cmp++;
            if (done_count !== m_cnt) begin
                n_err++;
                $display("FAIL mon_done_count: got %0d required %0d", done_count, m_cnt);
            end
            ox = m_full && out_ready;
            if (ox) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: got output %h with nothing expected", out_data);
                end else begin
                    exp_v = sb.pop_front();
                    if ({out_id, out_data} !== exp_v) begin
                        n_err++;
                        $display("FAIL sb_result: got id=%b data=%h required id=%b data=%h",
                                 out_id, out_data, exp_v[W], exp_v[W-1:0]);
                    end
                end
                m_cnt = m_cnt + 1'b1;
            end
            rx = 1'b0;
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, rev(req0_data)});
                m_last = 1'b0; rx = 1'b1;
                st0 = 0;
                st1 = req1_valid ? st1 + 1 : 0;
            end else if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, rev(req1_data)});
                m_last = 1'b1; rx = 1'b1;
                st1 = 0;
                st0 = req0_valid ? st0 + 1 : 0;
            end
            if (rx) begin
                n_cmp++;
                if (st0 > 1 || st1 > 1) begin
                    n_err++;
                    $display("FAIL starve: got skips %0d/%0d required <=1", st0, st1);
                end
            end
            if (!req0_valid) st0 = 0;
            if (!req1_valid) st1 = 0;
            m_full = rx ? 1'b1 : (ox ? 1'b0 : m_full);
        end
    end

    task automatic apply_reset;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        step; step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        req0_data = 8'h5A; req1_data = 8'hC3;
        step; step;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h required 00", out_data); end
        n_cmp++; if (out_id !== 1'b0) begin n_err++; $display("FAIL reset_out_id: got %b required 0", out_id); end
        n_cmp++; if (done_count !== 4'd0) begin n_err++; $display("FAIL reset_done_count: got %0d required 0", done_count); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready); end
        step;
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single;
        req0_valid = 1'b1; req0_data = 8'b11011010; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready: got %b%b required 10", req0_ready, req1_ready); end
        step;
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %b required 1", out_valid); end
        n_cmp++; if (out_data !== 8'b01011011) begin n_err++; $display("FAIL single_out_data: got %b required 01011011", out_data); end
        n_cmp++; if (out_id !== 1'b0) begin n_err++; $display("FAIL single_out_id: got %b required 0", out_id); end
        step;
        @(negedge clk);
        n_cmp++; if (done_count !== 4'd1) begin n_err++; $display("FAIL single_done_count: got %0d required 1", done_count); end
        step;
    endtask

    task automatic test_contention;
        logic [W-1:0] exp_d;
        apply_reset;
        req0_valid = 1'b1; req0_data = 8'h01;
        req1_valid = 1'b1; req1_data = 8'h80;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                n_cmp++;
                if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                    n_err++;
                    $display("FAIL contention_grant%0d: got %b%b required grant to %0d", i, req0_ready, req1_ready, i % 2);
                end
            end
            if (i >= 1) begin
                exp_d = ((i - 1) % 2 == 0) ? 8'h80 : 8'h01;
                n_cmp++;
                if (out_data !== exp_d || out_id !== ((i - 1) % 2 == 1)) begin
                    n_err++;
                    $display("FAIL contention_out%0d: got id=%b data=%h required data=%h", i, out_id, out_data, exp_d);
                end
            end
            step;
            if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        step;
    endtask

    task automatic test_backpressure;
        logic [CW-1:0] base;
        req0_valid = 1'b1; req0_data = 8'h3C ^ 8'h81; out_ready = 1'b1;
        @(negedge clk);
        base = done_count;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept: got %b required 1", req0_ready); end
        step;
        req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'hE2; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_data !== rev(8'hBD) || out_id !== 1'b0 || out_valid !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || done_count !== base) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b id=%b data=%h rdy=%b%b cnt=%0d required v=1 id=0 data=%h rdy=00 cnt=%0d",
                         i, out_valid, out_id, out_data, req0_ready, req1_ready, done_count, rev(8'hBD), base);
            end
            step;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b required 1", req1_ready); end
        step;
        req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_data !== 8'h47 || out_id !== 1'b1 || done_count !== base + 1'b1) begin
            n_err++;
            $display("FAIL bp_release_out: got id=%b data=%h cnt=%0d required id=1 data=47 cnt=%0d", out_id, out_data, done_count, base + 1'b1);
        end
        step; step;
    endtask

    task automatic test_wrap;
        int cnt_obs;
        apply_reset;
        cnt_obs = 0;
        req0_valid = 1'b1; req0_data = 8'h96; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done_count !== CW'(cnt_obs)) begin
                n_err++;
                $display("FAIL wrap_count%0d: got %0d required %0d", i, done_count, CW'(cnt_obs));
            end
            if (out_valid && out_ready) cnt_obs++;
            step;
            if (i == 16) req0_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (cnt_obs !== 17 || done_count !== 4'd1) begin n_err++; $display("FAIL wrap_final: got %0d transfers count %0d required 17 transfers count 1", cnt_obs, done_count); end
        step;
    endtask

    task automatic test_reset_mid;
        req0_valid = 1'b1; req0_data = 8'hF0; out_ready = 1'b1;
        step;
        req0_valid = 1'b0; out_ready = 1'b0;
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || done_count !== 4'd0) begin n_err++; $display("FAIL rmid_state: got v=%b cnt=%0d required v=0 cnt=0", out_valid, done_count); end
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL rmid_grant: got %b%b required 10", req0_ready, req1_ready); end
        step;
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        step; step;
    endtask

    task automatic test_stress;
        logic x0, x1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            x0 = req0_valid && req0_ready;
            x1 = req1_valid && req1_ready;
            step;
            if (!req0_valid || x0) begin req0_valid = ($urandom_range(0, 3) != 0); req0_data = W'($urandom); end
            if (!req1_valid || x1) begin req1_valid = ($urandom_range(0, 3) != 0); req1_data = W'($urandom); end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        step; step; step;
        @(negedge clk);
        n_cmp++; if (sb.size() != 0 || out_valid !== 1'b0) begin n_err++; $display("FAIL stress_drain: got %0d pending v=%b required 0 pending v=0", sb.size(), out_valid); end
    endtask

    initial begin
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_data = '0; req1_data = '0;
        test_reset;
        test_single;
        test_contention;
        test_backpressure;
        test_wrap;
        test_reset_mid;
        test_stress;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
